// File: rtl/nali_scan_pkg.sv
// -----------------------------------------------------------------------------
// nali_scan_pkg
// Shared definitions for the 16-channel mux scan sequencer:
//   - scan_state_e : sequencer state encoding
//   - NUM_CH       : number of mux channels scanned
//   - SEL_W        : width of the mux select
//   - CNT_W        : width of the asserted-channel count (0..NUM_CH)
//   - SETTLE_W     : width of the per-channel settle counter
// -----------------------------------------------------------------------------
package nali_scan_pkg;

  localparam int NUM_CH   = 16;
  localparam int SEL_W    = 4;
  localparam int CNT_W    = 5;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } scan_state_e;

endpackage

// File: rtl/nali_next_ch.sv
// -----------------------------------------------------------------------------
// nali_next_ch
// Combinational search for the next enabled channel.
//   mask_i  : channel enable vector, bit i = channel i
//   cur_i   : currently selected channel
//   first_i : 1 = ignore cur_i and return the lowest enabled channel
//   next_o  : lowest enabled channel strictly above cur_i (or lowest overall
//             when first_i is set); 0 when none exists
//   found_o : 1 when next_o names a real enabled channel
// -----------------------------------------------------------------------------
module nali_next_ch
  import nali_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              first_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);

  // Walk from the top channel downwards so the last qualifying hit wins,
  // which leaves the lowest qualifying index in next_o.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        next_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nali_16_scan.sv
// -----------------------------------------------------------------------------
// nali_16_scan
// Scan sequencer sitting upstream of a 16:1 mux. For every enabled channel it
// drives the mux select, waits SETTLE cycles, samples the mux output, and
// finally presents the full snapshot plus a count of asserted channels.
//   SETTLE  : settle cycles before the sampling edge (0..15)
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : begin a scan (honoured only when idle)
//   mask    : channel enables, latched when start is accepted
//   mux_out : single-bit output of the 16:1 mux
//   s       : mux select
//   busy    : scan in progress
//   done    : one-cycle pulse when result/count update
//   result  : sampled channel values, 0 for disabled channels
//   count   : number of ones in result
// -----------------------------------------------------------------------------
module nali_16_scan
  import nali_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] mask,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  s,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] result,
  output logic [CNT_W-1:0]  count
);

  // Last settle counter value before moving on to the sampling cycle.
  localparam int                  SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_LAST_I[SETTLE_W-1:0];

  // With no settle time a channel is entered straight in its sampling cycle.
  localparam scan_state_e DWELL_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  scan_state_e         state_q, state_d;
  logic [SEL_W-1:0]    s_q, s_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [NUM_CH-1:0]   work_q, work_d;
  logic [NUM_CH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NUM_CH-1:0]   nc_mask;
  logic                nc_first;
  logic [SEL_W-1:0]    nc_next;
  logic                nc_found;

  logic [NUM_CH-1:0]   work_sampled;
  logic [CNT_W-1:0]    sample_count;

  // While idle the search runs over the live mask so the first channel can be
  // loaded on the accepting edge; during the scan it uses the latched mask.
  assign nc_mask  = (state_q == ST_IDLE) ? mask : mask_q;
  assign nc_first = (state_q == ST_IDLE);

  nali_next_ch u_next_ch (
    .mask_i  (nc_mask),
    .cur_i   (s_q),
    .first_i (nc_first),
    .next_o  (nc_next),
    .found_o (nc_found)
  );

  // Working vector as it will look once the current channel is captured, and
  // its popcount, so the final sample lands in result on the same edge.
  always_comb begin
    work_sampled      = work_q;
    work_sampled[s_q] = mux_out;
    sample_count      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sample_count = sample_count + CNT_W'(work_sampled[i]);
    end
  end

  // Next-state and next-output logic; every output is registered so done,
  // busy and result change together on the edge that ends the scan.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = mask;
          work_d = '0;
          if (!nc_found) begin
            state_d  = ST_FINISH;
            done_d   = 1'b1;
            result_d = '0;
            count_d  = '0;
          end else begin
            s_d     = nc_next;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = DWELL_STATE;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        work_d = work_sampled;
        if (nc_found) begin
          s_d     = nc_next;
          cnt_d   = '0;
          state_d = DWELL_STATE;
        end else begin
          state_d  = ST_FINISH;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = work_sampled;
          count_d  = sample_count;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-scan drops
  // the partial snapshot entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s      = s_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign count  = count_q;

endmodule

// File: tb/tb_nali_16_scan.sv
// -----------------------------------------------------------------------------
// tb_nali_16_scan
// Two scanners (SETTLE=2 and SETTLE=0) share clock, reset, start and mask but
// each sees its own mux output. A cycle-level model derives the expected
// select/busy/done/result/count from the list of enabled channels and the
// sampling schedule; directed scans pin the model with literal values, then a
// randomized phase exercises start, mask, reset and mux_out freely.
// -----------------------------------------------------------------------------
module tb_nali_16_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mask;
  logic [1:0]  muxOut;
  logic [3:0]  sOut [2];
  logic [1:0]  busyOut;
  logic [1:0]  doneOut;
  logic [15:0] resultOut [2];
  logic [4:0]  countOut [2];

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;
  bit randMode    = 1'b0;
  logic [15:0] pattern = '0;
  logic [3:0]  sHist [0:255];

  // Model state, one slot per scanner.
  bit          mActive [2];
  int          mCyc [2];
  logic [15:0] mLatched [2];
  logic [15:0] mWork [2];
  logic [3:0]  expS [2];
  logic        expBusy [2];
  logic        expDone [2];
  logic [15:0] expResult [2];
  logic [4:0]  expCount [2];
  int          mPer;
  int          mN;

  always #5 clk = ~clk;

  nali_16_scan #(.SETTLE(2)) dutA (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mask    (mask),
    .mux_out (muxOut[0]),
    .s       (sOut[0]),
    .busy    (busyOut[0]),
    .done    (doneOut[0]),
    .result  (resultOut[0]),
    .count   (countOut[0])
  );

  nali_16_scan #(.SETTLE(0)) dutB (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mask    (mask),
    .mux_out (muxOut[1]),
    .s       (sOut[1]),
    .busy    (busyOut[1]),
    .done    (doneOut[1]),
    .result  (resultOut[1]),
    .count   (countOut[1])
  );

  function automatic int settleOf(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Index of the k-th (0-based) enabled channel, -1 if there is none.
  function automatic int nthSetBit(input logic [15:0] m, input int k);
    int c = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The mux: in directed mode it returns the pattern bit of the selected
  // channel, in random mode an unrelated random bit every cycle.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      muxOut[i] = randMode ? 1'($urandom_range(0, 1)) : pattern[sOut[i]];
    end
  end

  // Reference model: after acceptance, cycle c (1..N*(SETTLE+1)) selects the
  // enabled channel number (c-1)/(SETTLE+1); mux_out is captured at the end
  // of every cycle that is a multiple of SETTLE+1; the following cycle
  // presents the snapshot with done.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mPer = settleOf(i) + 1;
      mN   = $countones(mLatched[i]);
      if (rst) begin
        mActive[i]   = 1'b0;
        expS[i]      = '0;
        expBusy[i]   = 1'b0;
        expDone[i]   = 1'b0;
        expResult[i] = '0;
        expCount[i]  = '0;
      end else if (mActive[i]) begin
        if (mCyc[i] % mPer == 0)
          mWork[i][nthSetBit(mLatched[i], mCyc[i] / mPer - 1)] = muxOut[i];
        mCyc[i]++;
        if (mCyc[i] == mN * mPer + 1) begin
          mActive[i]   = 1'b0;
          expBusy[i]   = 1'b0;
          expDone[i]   = 1'b1;
          expResult[i] = mWork[i];
          expCount[i]  = 5'($countones(mWork[i]));
        end else begin
          expS[i] = 4'(nthSetBit(mLatched[i], (mCyc[i] - 1) / mPer));
        end
      end else if (expDone[i]) begin
        expDone[i] = 1'b0;
      end else if (start) begin
        mLatched[i] = mask;
        mWork[i]    = '0;
        if (mask == 16'h0000) begin
          expDone[i]   = 1'b1;
          expResult[i] = '0;
          expCount[i]  = '0;
        end else begin
          mActive[i] = 1'b1;
          mCyc[i]    = 1;
          expS[i]    = 4'(nthSetBit(mask, 0));
          expBusy[i] = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both scanners against the model.
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("s[%0d]", i), 32'(sOut[i]), 32'(expS[i]));
        checkOutput($sformatf("busy[%0d]", i), 32'(busyOut[i]), 32'(expBusy[i]));
        checkOutput($sformatf("done[%0d]", i), 32'(doneOut[i]), 32'(expDone[i]));
        checkOutput($sformatf("result[%0d]", i), 32'(resultOut[i]), 32'(expResult[i]));
        checkOutput($sformatf("count[%0d]", i), 32'(countOut[i]), 32'(expCount[i]));
      end
    end
  end

  // Pulses start for one edge and follows scanner inst until its done pulse,
  // recording the select per cycle. A second start with mask FFFF is pulsed
  // in cycle midCycle when nonzero. Returns at the negedge of the done cycle,
  // or with doneCycle = -1 if no done arrives within the budget.
  task automatic applyStimulus(input int inst, input logic [15:0] m,
                               input logic [15:0] pat, input int midCycle,
                               output int doneCycle);
    @(negedge clk);
    pattern = pat;
    mask    = m;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    mask      = 16'($urandom);
    doneCycle = -1;
    for (int c = 1; c <= 200; c++) begin
      sHist[c] = sOut[inst];
      if (doneOut[inst]) begin
        doneCycle = c;
        break;
      end
      if (c == midCycle) begin
        start = 1'b1;
        mask  = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int d;
    rst   = 1'b1;
    start = 1'b0;
    mask  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset s", 32'(sOut[0]), 32'h0);
    checkOutput("reset busy", 32'(busyOut[0]), 32'h0);
    checkOutput("reset done", 32'(doneOut[0]), 32'h0);
    checkOutput("reset result", 32'(resultOut[0]), 32'h0);
    checkOutput("reset count", 32'(countOut[0]), 32'h0);
    rst = 1'b0;

    // Full mask, SETTLE=2: three cycles per channel, done in cycle 49.
    applyStimulus(0, 16'hFFFF, 16'hA5C3, 0, d);
    checkOutput("full done cycle", 32'(d), 32'd49);
    checkOutput("full result", 32'(resultOut[0]), 32'hA5C3);
    checkOutput("full count", 32'(countOut[0]), 32'd8);
    checkOutput("full busy at done", 32'(busyOut[0]), 32'h0);
    checkOutput("full s cycle1", 32'(sHist[1]), 32'd0);
    checkOutput("full s cycle3", 32'(sHist[3]), 32'd0);
    checkOutput("full s cycle4", 32'(sHist[4]), 32'd1);
    checkOutput("full s cycle48", 32'(sHist[48]), 32'd15);

    // Back-to-back: start in the cycle right after done.
    applyStimulus(0, 16'hFFFF, 16'h3C5A, 0, d);
    checkOutput("b2b done cycle", 32'(d), 32'd49);
    checkOutput("b2b result", 32'(resultOut[0]), 32'h3C5A);
    checkOutput("b2b count", 32'(countOut[0]), 32'd8);
    repeat (20) @(negedge clk);

    // SETTLE=0, channels 0 and 15 only.
    applyStimulus(1, 16'h8001, 16'h8001, 0, d);
    checkOutput("ends done cycle", 32'(d), 32'd3);
    checkOutput("ends s cycle1", 32'(sHist[1]), 32'd0);
    checkOutput("ends s cycle2", 32'(sHist[2]), 32'd15);
    checkOutput("ends result", 32'(resultOut[1]), 32'h8001);
    checkOutput("ends count", 32'(countOut[1]), 32'd2);
    repeat (20) @(negedge clk);

    // Empty mask: immediate done, busy never rises.
    applyStimulus(0, 16'h0000, 16'hFFFF, 0, d);
    checkOutput("empty done cycle", 32'(d), 32'd1);
    checkOutput("empty busy", 32'(busyOut[0]), 32'h0);
    checkOutput("empty result", 32'(resultOut[0]), 32'h0);
    checkOutput("empty count", 32'(countOut[0]), 32'd0);
    repeat (5) @(negedge clk);

    // Restart attempt mid-scan must be ignored.
    applyStimulus(0, 16'h00F0, 16'hFFFF, 3, d);
    checkOutput("midstart done cycle", 32'(d), 32'd13);
    checkOutput("midstart result", 32'(resultOut[0]), 32'h00F0);
    checkOutput("midstart count", 32'(countOut[0]), 32'd4);
    repeat (20) @(negedge clk);

    // Reset in cycle 20 of a full scan, then a fresh scan.
    pattern = 16'hFFFF;
    mask    = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort s", 32'(sOut[0]), 32'h0);
    checkOutput("abort busy", 32'(busyOut[0]), 32'h0);
    checkOutput("abort done", 32'(doneOut[0]), 32'h0);
    checkOutput("abort result", 32'(resultOut[0]), 32'h0);
    repeat (60) @(negedge clk);
    applyStimulus(0, 16'hFFFF, 16'h1234, 0, d);
    checkOutput("fresh done cycle", 32'(d), 32'd49);
    checkOutput("fresh result", 32'(resultOut[0]), 32'h1234);
    checkOutput("fresh count", 32'(countOut[0]), 32'd5);

    // Randomized phase: random starts, masks, resets and mux output.
    randMode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       mask = 16'h0000;
        1:       mask = 16'hFFFF;
        2:       mask = 16'h0001 << $urandom_range(0, 15);
        3:       mask = 16'h8000;
        default: mask = 16'($urandom);
      endcase
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (80) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
